jt49_dcdec: RTL and testbench

JT49_DCDEC -- requirements
Module: jt49_dcdec

---
 rtl/jt49_dcdec_if.sv | 13 +
 rtl/jt49_dcdec.sv | 127 ++++++++++++
 tb/tb_jt49_dcdec.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/jt49_dcdec_if.sv
// Output sample stream of jt49_dcdec.
//   dout       : signed 16-bit DC-removed sample at the FIFO head
//   dout_valid : FIFO non-empty, dout is meaningful
//   dout_ready : consumer accepts dout on a clock edge where dout_valid=1
// master = sample producer (jt49_dcdec), slave = sample consumer.
interface jt49_dcdec_if;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/jt49_dcdec.sv
// jt49_dcdec: decimating DC-blocker for the combined PSG output.
// Averages 2^DECIM_LOG2 input samples, subtracts a slowly tracking DC
// estimate and queues the result in a 2-entry FIFO.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cen        : clock enable for sample acceptance
//   din        : unsigned 10-bit PSG sample
//   din_stb    : new-sample strobe (qualified by cen)
//   ovf        : sticky overflow, set when a sample is dropped
//   ovf_clr    : synchronous clear of ovf (a coincident set wins)
//   out_if     : output stream (dout / dout_valid / dout_ready)
module jt49_dcdec #(
    parameter int DECIM_LOG2 = 2,
    parameter int DC_SHIFT   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [9:0]        din,
    input  logic              din_stb,
    output logic              ovf,
    input  logic              ovf_clr,
    jt49_dcdec_if.master      out_if
);
    // Phase counter keeps at least one bit so DECIM_LOG2=0 stays legal;
    // in that case LAST is 0 and every take is the final one.
    localparam int PW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int AW = 10 + DECIM_LOG2;
    localparam int DW = 10 + DC_SHIFT;
    localparam logic [PW-1:0] LAST = PW'((1 << DECIM_LOG2) - 1);

    logic          take, final_take;
    logic [PW-1:0] phase_q, phase_d;
    logic [AW-1:0] acc_q, acc_d, sum;
    logic [9:0]    avg, dc_int;
    logic [DW-1:0] dc_q, dc_d;
    logic [10:0]   y;
    logic [15:0]   sample;

    logic [15:0]   mem_q [2];
    logic [15:0]   mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [15:0]   last_q, last_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, push_ok, drop;

    assign take       = cen & din_stb;
    assign final_take = take & (phase_q == LAST);

    // acc never overflows: at most (2^D - 1) * 1023 before the final add.
    assign sum    = acc_q + AW'(din);
    assign avg    = 10'(sum >> DECIM_LOG2);
    assign dc_int = dc_q[DW-1:DC_SHIFT];
    assign y      = {1'b0, avg} - {1'b0, dc_int};
    assign sample = {y, 5'b0};

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign pop     = ~empty & out_if.dout_ready;
    // A pop on the same edge frees the slot the write pointer lands on.
    assign push_ok = final_take & (~full | pop);
    assign drop    = final_take & full & ~pop;

    always_comb begin
        phase_d  = phase_q;
        acc_d    = acc_q;
        dc_d     = dc_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push_ok} - {1'b0, pop};
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
        ovf_d    = ovf_q;

        if (take) begin
            phase_d = final_take ? '0 : phase_q + 1'b1;
            acc_d   = final_take ? '0 : sum;
        end
        // dc tracks even when the sample itself is dropped.
        if (final_take) begin
            dc_d = dc_q + DW'(avg) - DW'(dc_int);
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = sample;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            acc_q    <= '0;
            dc_q     <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            acc_q    <= acc_d;
            dc_q     <= dc_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    // While empty, dout holds the last popped sample (0 after reset).
    assign out_if.dout       = empty ? last_q : mem_q[rd_ptr_q];
    assign out_if.dout_valid = ~empty;
    assign ovf               = ovf_q;

endmodule

// File: tb/tb_jt49_dcdec.sv
// Directed bench for jt49_dcdec (DECIM_LOG2=2, DC_SHIFT=8).
module tb_jt49_dcdec;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic [9:0] din;
    logic       din_stb;
    logic       ovf;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;
    int got[$];

    jt49_dcdec_if out_if ();

    jt49_dcdec #(.DECIM_LOG2(2), .DC_SHIFT(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .din     (din),
        .din_stb (din_stb),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .out_if  (out_if)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, so the values seen at
    // the falling edge are exactly the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (rst_n && out_if.dout_valid && out_if.dout_ready)
            got.push_back(int'($signed(out_if.dout)));
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take(input logic [9:0] d);
        din     = d;
        cen     = 1'b1;
        din_stb = 1'b1;
        tick();
        din_stb = 1'b0;
    endtask

    task automatic block(input logic [9:0] d);
        repeat (4) take(d);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        got.delete();
    endtask

    initial begin
        rst_n             = 1'b0;
        cen               = 1'b0;
        din               = '0;
        din_stb           = 1'b0;
        ovf_clr           = 1'b0;
        out_if.dout_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset from a full, overflowed state
        block(10'd512);
        block(10'd512);
        block(10'd512);
        check("pre_rst_dout", int'($signed(out_if.dout)), 16384);
        check("pre_rst_valid", int'(out_if.dout_valid), 1);
        check("pre_rst_ovf", int'(ovf), 1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_dout", int'($signed(out_if.dout)), 0);
        check("rst_valid", int'(out_if.dout_valid), 0);
        check("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        got.delete();

        // First two blocks
        out_if.dout_ready = 1'b1;
        block(10'd512);
        tick(); tick();
        check("blk1_count", got.size(), 1);
        if (got.size() > 0) check("blk1_dout", got[0], 16384);
        check("blk1_dcint", int'(dut.dc_q >> 8), 2);
        check("blk1_empty", int'(out_if.dout_valid), 0);
        check("blk1_hold", int'($signed(out_if.dout)), 16384);
        got.delete();
        block(10'd512);
        tick(); tick();
        check("blk2_count", got.size(), 1);
        if (got.size() > 0) check("blk2_dout", got[0], 16320);

        // DC convergence
        for (int i = 0; i < 2998; i++) block(10'd512);
        tick(); tick();
        check("dc_conv", int'(dut.dc_q), 131072);
        got.delete();
        repeat (3) block(10'd512);
        tick(); tick();
        check("conv_count", got.size(), 3);
        for (int i = 0; i < got.size(); i++) check("conv_zero", got[i], 0);
        got.delete();
        block(10'd600);
        tick(); tick();
        check("step_count", got.size(), 1);
        if (got.size() > 0) check("step_dout", got[0], 2816);

        // Backpressure and overflow
        do_reset();
        out_if.dout_ready = 1'b0;
        block(10'd1023);
        block(10'd0);
        check("bp_ovf_before", int'(ovf), 0);
        block(10'd0);
        block(10'd0);
        check("bp_ovf", int'(ovf), 1);
        check("bp_head", int'($signed(out_if.dout)), 32736);
        check("bp_fill", int'(dut.cnt_q), 2);
        out_if.dout_ready = 1'b1;
        repeat (4) tick();
        check("bp_pops", got.size(), 2);
        if (got.size() > 1) begin
            check("bp_pop0", got[0], 32736);
            check("bp_pop1", got[1], -96);
        end
        check("bp_valid", int'(out_if.dout_valid), 0);
        check("bp_hold", int'($signed(out_if.dout)), -96);
        check("bp_ovf_sticky", int'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("bp_ovf_clr", int'(ovf), 0);

        // cen gating
        do_reset();
        din     = 10'd100;
        cen     = 1'b0;
        din_stb = 1'b1;
        repeat (8) tick();
        din_stb = 1'b0;
        tick(); tick();
        check("cen0_phase", int'(dut.phase_q), 0);
        check("cen0_count", got.size(), 0);
        check("cen0_valid", int'(out_if.dout_valid), 0);
        take(10'd100);
        take(10'd100);
        check("cen1_phase", int'(dut.phase_q), 2);
        repeat (6) take(10'd100);
        tick(); tick();
        check("cen1_count", got.size(), 2);
        for (int i = 0; i < got.size(); i++) check("cen1_dout", got[i], 3200);

        // Reset in the middle of a block
        do_reset();
        take(10'd1000);
        take(10'd1000);
        do_reset();
        block(10'd256);
        tick(); tick(); tick();
        check("midrst_count", got.size(), 1);
        if (got.size() > 0) check("midrst_dout", got[0], 8192);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
